// File: rtl/dmem_byte_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_byte_responder_if
//  Purpose  : CPU data-side request/response bundle for the byte responder.
//  Revision : 1.0
// ============================================================================
interface dmem_byte_responder_if;
    logic        mem_read;
    logic [1:0]  mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;

    modport master (
        output mem_read, mem_write, address, write_data,
        input  read_data, stall
    );

    modport slave (
        input  mem_read, mem_write, address, write_data,
        output read_data, stall
    );
endinterface
`default_nettype wire

// File: rtl/dmem_byte_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_byte_responder
//  Purpose  : Serialises CPU word/half/byte data accesses onto an 8-bit SRAM.
//  Revision : 1.0
// ============================================================================
module dmem_byte_responder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    dmem_byte_responder_if.slave cpu,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    input  logic [7:0]        sram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [1:0]        cnt, cnt_nx;
    logic [1:0]        last;
    logic              is_write;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic              cs_nx, we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        wdata_nx;
    logic [1:0]        cap_idx;
    logic              req;
    logic [31-ADDR_W:0] unused_addr_hi;

    assign req            = cpu.mem_read | (cpu.mem_write != 2'b00);
    assign cpu.stall      = req & (state != DONE);
    assign cap_idx        = cnt - 2'd1;
    assign unused_addr_hi = cpu.address[31:ADDR_W];

    // SRAM controls are computed one cycle ahead so the byte for cnt is on the bus during ACCESS(cnt)
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cs_nx    = 1'b0;
        we_nx    = 1'b0;
        addr_nx  = sram_addr;
        wdata_nx = sram_wdata;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = ACCESS;
                    cnt_nx   = 2'd0;
                    cs_nx    = 1'b1;
                    we_nx    = (cpu.mem_write != 2'b00);
                    addr_nx  = cpu.address[ADDR_W-1:0];
                    wdata_nx = cpu.write_data[7:0];
                end
            end
            ACCESS: begin
                if (cnt == last) begin
                    state_nx = is_write ? DONE : WAIT;
                end else begin
                    cnt_nx   = cnt + 2'd1;
                    cs_nx    = 1'b1;
                    we_nx    = is_write;
                    addr_nx  = base + ADDR_W'(cnt_nx);
                    wdata_nx = wdata[{cnt_nx, 3'b000} +: 8];
                end
            end
            WAIT:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            last       <= 2'd0;
            is_write   <= 1'b0;
            base       <= '0;
            wdata      <= 32'd0;
            sram_cs    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= 8'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sram_cs    <= cs_nx;
            sram_we    <= we_nx;
            sram_addr  <= addr_nx;
            sram_wdata <= wdata_nx;
            if (state == IDLE && req) begin
                is_write <= (cpu.mem_write != 2'b00);
                base     <= cpu.address[ADDR_W-1:0];
                wdata    <= cpu.write_data;
                case (cpu.mem_write)
                    2'b01:   last <= 2'd0;
                    2'b10:   last <= 2'd1;
                    default: last <= 2'd3;
                endcase
            end
        end
    end

    // Each load byte returns one cycle after its issue; the last one lands in WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu.read_data <= 32'd0;
        end else if (state == ACCESS && !is_write && cnt != 2'd0) begin
            cpu.read_data[{cap_idx, 3'b000} +: 8] <= sram_rdata;
        end else if (state == WAIT) begin
            cpu.read_data[31:24] <= sram_rdata;
        end
    end

endmodule
`default_nettype wire
